keypad_scan_ctrl: RTL and testbench
===================================

KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

Interface
REQ-001 Parameter SCAN_CYCLES, default 4: clock cycles each column is driven during scanning; minimum 3.
REQ-002 Parameter DEBOUNCE_CYCLES, default 8: consecutive stable cycles required to accept a press or a release; minimum 2.
REQ-003 clk  input  1  single system clock; all flops are on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 row  input  4  keypad rows, active-low, externally pulled up, asynchronous to clk.
REQ-006 col  output  4  column drive, active-low one-hot; exactly one bit is low at all times after reset.
REQ-007 new_key  output  1  one-cycle pulse marking an accepted key press.
REQ-008 key_pressed_value  output  16  one-hot code of the last accepted key, bit index = row*4 + col.

Function
REQ-009 row SHALL pass through a 2-flop synchronizer; all FSM decisions use the synchronized value row_s, giving 2 cycles of input latency.
REQ-010 States are SCAN, DEBOUNCE, HELD and RELEASE; a single counter dcnt serves both dwell and debounce timing.
REQ-011 SCAN: col steps col0->col1->col2->col3->col0, each column held SCAN_CYCLES cycles; row_s is evaluated only on the last dwell cycle of each column.
REQ-012 SCAN, on that last dwell cycle with row_s != 4'hF: latch the column index and the lowest-index low row bit, freeze col, clear dcnt, and go to DEBOUNCE.
REQ-013 Multiple rows low on the same column SHALL resolve to the lowest row index; other columns are not examined until the return to SCAN.
REQ-014 DEBOUNCE: while the latched row bit stays low, dcnt increments each cycle.
REQ-015 DEBOUNCE, on the cycle where dcnt == DEBOUNCE_CYCLES-1 and the bit is still low: on the next edge, assert new_key for exactly 1 cycle, load key_pressed_value, and go to HELD.
REQ-016 DEBOUNCE, if the latched bit goes high at any point: clear dcnt, return to SCAN, and advance to the next column; no pulse and no value change.
REQ-017 HELD: col stays frozen and other keys are ignored; when the latched bit goes high, clear dcnt and go to RELEASE.
REQ-018 RELEASE: after DEBOUNCE_CYCLES consecutive cycles with the bit high, go to SCAN and advance to the next column.
REQ-019 RELEASE, if the bit goes low before that count: go back to HELD with no new_key.
REQ-020 key_pressed_value SHALL hold its value until the next accepted press; new_key is never asserted in SCAN, HELD or RELEASE.
REQ-021 A key held indefinitely SHALL produce exactly one new_key pulse; auto-repeat is not provided.

Reset
REQ-022 While reset is asserted: state = SCAN, col = 4'b1110, dcnt = 0, synchronizer flops = 4'hF, new_key = 0, key_pressed_value = 16'h0000.
REQ-023 Reset asserted mid-DEBOUNCE, mid-HELD or mid-RELEASE SHALL abort the operation immediately with no new_key pulse.
REQ-024 After reset deasserts, scanning restarts at col0 with a full SCAN_CYCLES dwell.

Structure
REQ-025 Package keypad_pkg SHALL hold the state enum typedef and the default SCAN_CYCLES and DEBOUNCE_CYCLES constants, shared with store_keypresses and the benches.
REQ-026 One sub-module, sync2 (a parameterized-width 2-flop synchronizer), SHALL be instantiated for row.
REQ-027 The RTL SHALL contain one FSM and one counter, with no latches.

Verification (SCAN_CYCLES=4, DEBOUNCE_CYCLES=8)
REQ-028 Idle: row = 4'hF for 64 cycles -> col cycles E,D,B,7 every 4 cycles; new_key stays 0; key_pressed_value stays 0.
REQ-029 Clean press: row1 low while col2 is driven, held 40 cycles -> exactly one new_key pulse with key_pressed_value = 16'h0040; col frozen at 4'b1011 until the release is debounced.
REQ-030 Bounce: row0 low for 3 cycles on col0, then high -> no new_key, state returns to SCAN, col advances to 4'b1101.
REQ-031 Release bounce: while HELD on key 16'h0001, row toggles high 3 cycles then low -> no second pulse; after a final high for 8 cycles, scanning resumes.
REQ-032 Simultaneous press: rows 2 and 3 low on col3 -> key_pressed_value = 16'h0800 (row 2, col 3); a second key pressed while HELD -> no pulse.
REQ-033 Reset mid-DEBOUNCE: assert reset at dcnt = 5 -> new_key stays 0, col = 4'b1110, key_pressed_value = 16'h0000.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared scan FSM state type, default timing constants and index helpers.
package keypad_pkg;

   typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

   localparam int SCAN_CYCLES_DEF     = 4;
   localparam int DEBOUNCE_CYCLES_DEF = 8;

   // Lowest-index low bit of an active-low 4-bit vector (caller guarantees one is low).
   function automatic logic [1:0] low_idx(input logic [3:0] v);
      return !v[0] ? 2'd0 : !v[1] ? 2'd1 : !v[2] ? 2'd2 : 2'd3;
   endfunction

endpackage

// File: rtl/sync2.sv
// sync2: parameterized-width two-flop synchronizer, resets to all ones (idle rows).
module sync2 #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] s1_q, s2_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q <= '1;
         s2_q <= '1;
      end else begin
         s1_q <= d_i;
         s2_q <= s1_q;
      end
   end

   assign q_o = s2_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 keypad column scanner with press/release debounce and one-hot key report.
module keypad_scan_ctrl
   import keypad_pkg::*;
#(
   parameter int SCAN_CYCLES     = SCAN_CYCLES_DEF,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  row,
   output logic [3:0]  col,
   output logic        new_key,
   output logic [15:0] key_pressed_value
);

   localparam int CW = $clog2(SCAN_CYCLES > DEBOUNCE_CYCLES ? SCAN_CYCLES : DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_CYCLES - 1);
   localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);

   state_t        state_q;
   logic [CW-1:0] dcnt_q;
   logic [3:0]    col_q;
   logic [1:0]    rsel_q;
   logic [1:0]    csel_q;
   logic          new_key_q;
   logic [15:0]   kpv_q;
   logic [3:0]    row_s;
   logic          key_low;
   logic [3:0]    col_nxt;

   sync2 #(.W(4)) u_sync (
      .clk (clk),
      .rst (reset),
      .d_i (row),
      .q_o (row_s)
   );

   assign key_low = ~row_s[rsel_q];
   assign col_nxt = {col_q[2:0], col_q[3]};

   // One counter times both the column dwell and the press/release debounce.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= SCAN;
         dcnt_q    <= '0;
         col_q     <= 4'b1110;
         rsel_q    <= 2'd0;
         csel_q    <= 2'd0;
         new_key_q <= 1'b0;
         kpv_q     <= 16'h0000;
      end else begin
         new_key_q <= 1'b0;
         case (state_q)
            SCAN: begin
               if (dcnt_q == SCAN_LAST) begin
                  dcnt_q <= '0;
                  if (row_s != 4'hF) begin
                     rsel_q  <= low_idx(row_s);
                     csel_q  <= low_idx(col_q);
                     state_q <= DEBOUNCE;
                  end else begin
                     col_q <= col_nxt;
                  end
               end else begin
                  dcnt_q <= dcnt_q + 1'b1;
               end
            end
            DEBOUNCE: begin
               if (!key_low) begin
                  dcnt_q  <= '0;
                  col_q   <= col_nxt;
                  state_q <= SCAN;
               end else if (dcnt_q == DB_LAST) begin
                  dcnt_q    <= '0;
                  new_key_q <= 1'b1;
                  kpv_q     <= 16'(1) << {rsel_q, csel_q};
                  state_q   <= HELD;
               end else begin
                  dcnt_q <= dcnt_q + 1'b1;
               end
            end
            HELD: begin
               if (!key_low) begin
                  dcnt_q  <= '0;
                  state_q <= RELEASE;
               end
            end
            RELEASE: begin
               if (key_low) begin
                  dcnt_q  <= '0;
                  state_q <= HELD;
               end else if (dcnt_q == DB_LAST) begin
                  dcnt_q  <= '0;
                  col_q   <= col_nxt;
                  state_q <= SCAN;
               end else begin
                  dcnt_q <= dcnt_q + 1'b1;
               end
            end
            default: state_q <= SCAN;
         endcase
      end
   end

   assign col               = col_q;
   assign new_key           = new_key_q;
   assign key_pressed_value = kpv_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: keypad matrix model drives rows from col; pulses checked against a scoreboard.
module tb_keypad_scan_ctrl;
   import keypad_pkg::*;

   logic        clk   = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  row;
   logic [3:0]  col;
   logic        new_key;
   logic [15:0] kpv;
   logic [15:0] keys = 16'h0000;

   int          errors = 0;
   int          checks = 0;
   int          pulses = 0;
   logic        nk_prev = 1'b0;
   logic [15:0] exp_q[$];

   typedef struct {
      logic [15:0] keys;
      logic [15:0] keys2;
      int          h1;
      int          h2;
      logic [15:0] kpv;
      int          c;
   } vec_t;

   vec_t vecs[5];

   keypad_scan_ctrl #(
      .SCAN_CYCLES     (SCAN_CYCLES_DEF),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES_DEF)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .row               (row),
      .col               (col),
      .new_key           (new_key),
      .key_pressed_value (kpv)
   );

   always #5 clk = ~clk;

   // A row reads low when a pressed key connects it to the currently driven column.
   always_comb begin
      row = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r*4+c] && col[c] === 1'b0) row[r] = 1'b0;
   end

   function automatic logic [3:0] colv(input int k);
      logic [3:0] one;
      one = 4'b0001;
      return ~(one << (k % 4));
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Advance one cycle, sampling at the falling edge; every pulse is popped against the scoreboard.
   task automatic tick();
      @(negedge clk);
      if (!reset) begin
         chk("col_onehot", $countones(~col), 1);
         if (new_key) begin
            chk("new_key_width", {31'b0, nk_prev}, 0);
            if (!nk_prev) begin
               pulses++;
               if (exp_q.size() == 0) chk("spurious_new_key", {31'b0, new_key}, 0);
               else chk("pulse_kpv", {16'b0, kpv}, {16'b0, exp_q.pop_front()});
            end
         end
         nk_prev = new_key;
      end
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic wait_col(input logic [3:0] c, input string name);
      logic [3:0] p;
      int k;
      k = 0;
      do begin
         p = col;
         tick();
         k++;
      end while (!(col === c && p !== c) && k < 100);
      chk({name, "_col_start"}, {31'b0, (col === c && p !== c)}, 1);
   endtask

   task automatic wait_leave(input logic [3:0] c, input logic [3:0] nxt, input string name);
      int k;
      k = 0;
      while (col === c && k < 40) begin
         tick();
         k++;
      end
      chk({name, "_next_col"}, {28'b0, col}, {28'b0, nxt});
   endtask

   initial begin
      int p0;
      vecs[0] = '{16'h0040, 16'h0000, 40, 0,  16'h0040, 2};
      vecs[1] = '{16'h0001, 16'h0010, 36, 10, 16'h0001, 0};
      vecs[2] = '{16'h8800, 16'h0008, 36, 10, 16'h0800, 3};
      vecs[3] = '{16'h0110, 16'h0002, 36, 10, 16'h0010, 0};
      vecs[4] = '{16'h8000, 16'h0000, 36, 0,  16'h8000, 3};

      #2 reset = 1'b1;
      @(negedge clk);
      chk("reset_col", {28'b0, col}, 32'h0000_000E);
      chk("reset_new_key", {31'b0, new_key}, 0);
      chk("reset_kpv", {16'b0, kpv}, 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // Idle scan: full dwell per column starting at col0
      for (int i = 0; i < 64; i++) begin
         chk("idle_col", {28'b0, col}, {28'b0, colv(i / 4)});
         tick();
      end
      chk("idle_pulses", pulses, 0);
      chk("idle_kpv", {16'b0, kpv}, 0);

      // Short press on col0: debounce entered, then abandoned
      wait_col(4'b1110, "bounce");
      p0 = pulses;
      keys = 16'h0001;
      ticks(4);
      keys = 16'h0000;
      ticks(1);
      chk("bounce_frozen", {28'b0, col}, 32'hE);
      ticks(2);
      chk("bounce_advance", {28'b0, col}, 32'hD);
      chk("bounce_pulses", pulses - p0, 0);
      chk("bounce_kpv", {16'b0, kpv}, 0);

      // Table of presses, each with an extra key added while held
      foreach (vecs[i]) begin
         p0 = pulses;
         exp_q.push_back(vecs[i].kpv);
         keys = vecs[i].keys;
         ticks(vecs[i].h1);
         keys = vecs[i].keys | vecs[i].keys2;
         ticks(vecs[i].h2);
         chk("held_col", {28'b0, col}, {28'b0, colv(vecs[i].c)});
         keys = 16'h0000;
         ticks(DEBOUNCE_CYCLES_DEF);
         chk("release_col", {28'b0, col}, {28'b0, colv(vecs[i].c)});
         wait_leave(colv(vecs[i].c), colv(vecs[i].c + 1), "vec");
         chk("vec_pulses", pulses - p0, 1);
         chk("vec_kpv", {16'b0, kpv}, {16'b0, vecs[i].kpv});
         chk("vec_sb_empty", exp_q.size(), 0);
      end

      // Release bounce while held on key 0
      wait_col(4'b1110, "relb");
      p0 = pulses;
      exp_q.push_back(16'h0001);
      keys = 16'h0001;
      ticks(20);
      chk("relb_first_pulse", pulses - p0, 1);
      keys = 16'h0000;
      ticks(3);
      keys = 16'h0001;
      ticks(10);
      chk("relb_frozen", {28'b0, col}, 32'hE);
      chk("relb_no_second", pulses - p0, 1);
      keys = 16'h0000;
      ticks(DEBOUNCE_CYCLES_DEF);
      chk("relb_still_frozen", {28'b0, col}, 32'hE);
      wait_leave(4'b1110, 4'b1101, "relb");
      chk("relb_kpv", {16'b0, kpv}, 32'h1);

      // Reset at dcnt = 5 in debounce on col1
      wait_col(4'b1101, "rstdb");
      p0 = pulses;
      keys = 16'h0002;
      ticks(9);
      reset = 1'b1;
      keys = 16'h0000;
      #1;
      chk("rstdb_col", {28'b0, col}, 32'hE);
      chk("rstdb_new_key", {31'b0, new_key}, 0);
      chk("rstdb_kpv", {16'b0, kpv}, 0);
      @(negedge clk);
      chk("rstdb_new_key_hold", {31'b0, new_key}, 0);
      @(negedge clk);
      reset = 1'b0;
      nk_prev = 1'b0;
      for (int i = 0; i < 12; i++) begin
         chk("rstdb_restart_col", {28'b0, col}, {28'b0, colv(i / 4)});
         tick();
      end
      chk("rstdb_pulses", pulses - p0, 0);
      chk("final_sb_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
